// File: rtl/i2c_expander_seq_if.sv
// -----------------------------------------------------------------------------
// i2c_expander_seq_if
//
// Purpose:
//   Request/complete handshake between the expander command sequencer and the
//   I2C expander MM bridge that fronts the I2C master core register file.
//
// Signals:
//   wr_rq        sequencer -> bridge  write request (level, held until done)
//   rd_rq        sequencer -> bridge  read request (level, held until done)
//   wr_adr[3:0]  sequencer -> bridge  core register address for writes
//   rd_adr[3:0]  sequencer -> bridge  core register address for reads
//   wr_data[31:0] sequencer -> bridge core write data
//   rd_data[31:0] bridge -> sequencer core read data, valid with action_done
//   action_done  bridge -> sequencer  one-cycle access-complete pulse
//
// Modports:
//   master  the sequencer side
//   slave   the bridge side
// -----------------------------------------------------------------------------
interface i2c_expander_seq_if;
    logic        wr_rq;
    logic        rd_rq;
    logic [3:0]  wr_adr;
    logic [3:0]  rd_adr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        action_done;

    modport master (
        output wr_rq, rd_rq, wr_adr, rd_adr, wr_data,
        input  rd_data, action_done
    );

    modport slave (
        input  wr_rq, rd_rq, wr_adr, rd_adr, wr_data,
        output rd_data, action_done
    );
endinterface

// File: rtl/i2c_expander_seq.sv
// -----------------------------------------------------------------------------
// i2c_expander_seq
//
// Purpose:
//   Command sequencer in front of the I2C expander MM bridge. It turns a single
//   expander register read or write into the ordered list of I2C master core
//   accesses: one-time core init, TFR_CMD pushes, STATUS polling, RX level
//   polling and the RX_DATA fetch. Read data and an error flag are handed back
//   to the GPIO control logic with a one-cycle completion pulse.
//
// Optional feature (compile-time macro I2C_EXP_NACK_CHECK_EN):
//   When defined, the ISR is read after the transfer goes idle; a latched NACK
//   is cleared (write-1-clear) and reported through rsp_err_o. When undefined
//   the ISR is never touched and rsp_err_o only reports poll timeouts.
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-high reset
//   cmd_valid_i   command request
//   cmd_ready_o   idle and initialised; accept on cmd_valid_i && cmd_ready_o
//   cmd_write_i   1 = expander register write, 0 = read
//   cmd_reg_i     expander register index
//   cmd_wdata_i   write byte
//   rsp_valid_o   one-cycle completion pulse
//   rsp_rdata_o   read byte (held until the next read completes)
//   rsp_err_o     error qualifier, valid with rsp_valid_o
//   bus           bridge request/complete handshake (master modport)
// -----------------------------------------------------------------------------
module i2c_expander_seq #(
    parameter logic [6:0]  DEV_ADDR     = 7'h20,
    parameter logic [31:0] SCL_LOW_CNT  = 32'd250,
    parameter logic [31:0] SCL_HIGH_CNT = 32'd250,
    parameter logic [31:0] SDA_HOLD_CNT = 32'd30,
    parameter logic [15:0] POLL_MAX     = 16'd1000
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [7:0]                cmd_reg_i,
    input  logic [7:0]                cmd_wdata_i,

    output logic                      rsp_valid_o,
    output logic [7:0]                rsp_rdata_o,
    output logic                      rsp_err_o,

    i2c_expander_seq_if.master        bus
);

    // Core register map
    localparam logic [3:0] REG_TFR_CMD  = 4'd0;
    localparam logic [3:0] REG_RX_DATA  = 4'd1;
    localparam logic [3:0] REG_CTRL     = 4'd2;
    localparam logic [3:0] REG_ISR      = 4'd4;
    localparam logic [3:0] REG_STATUS   = 4'd5;
    localparam logic [3:0] REG_RX_LVL   = 4'd7;
    localparam logic [3:0] REG_SCL_LOW  = 4'd8;
    localparam logic [3:0] REG_SCL_HIGH = 4'd9;
    localparam logic [3:0] REG_SDA_HOLD = 4'd10;

    // TFR_CMD words: [9]=STA, [8]=STO, [7:0]=byte
    localparam logic [31:0] TFR_ADDR_WR = {22'd0, 2'b10, DEV_ADDR, 1'b0};
    localparam logic [31:0] TFR_ADDR_RD = {22'd0, 2'b10, DEV_ADDR, 1'b1};
    localparam logic [31:0] TFR_RD_STOP = {22'd0, 2'b01, 8'h00};

    localparam logic [31:0] ISR_NACK_CLR = 32'h0000_0004;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_PUSH,
        ST_POLL_STAT,
        ST_ISR_RD,
        ST_ISR_CLR,
        ST_POLL_RX,
        ST_RX_RD,
        ST_RESP
    } state_e;

    state_e      state_q,     state_d;
    logic [1:0]  step_q,      step_d;       // access index inside INIT / PUSH
    logic        wr_rq_q,     wr_rq_d;
    logic        rd_rq_q,     rd_rq_d;
    logic [3:0]  wr_adr_q,    wr_adr_d;
    logic [3:0]  rd_adr_q,    rd_adr_d;
    logic [31:0] wr_data_q,   wr_data_d;
    logic [15:0] poll_cnt_q,  poll_cnt_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;
    logic        cmd_write_q, cmd_write_d;
    logic [7:0]  cmd_reg_q,   cmd_reg_d;
    logic [7:0]  cmd_wdata_q, cmd_wdata_d;

    // Access the current state wants to issue next
    logic        iss_wr;
    logic        iss_rd;
    logic [3:0]  iss_adr;
    logic [31:0] iss_data;

    logic        access_busy;
    logic        access_done;
    logic [15:0] poll_cnt_inc;
    logic        poll_expired;
    logic [1:0]  push_last;

    assign access_busy  = wr_rq_q | rd_rq_q;
    assign access_done  = access_busy & bus.action_done;
    assign poll_cnt_inc = poll_cnt_q + 16'd1;
    assign poll_expired = (poll_cnt_inc >= POLL_MAX);
    assign push_last    = cmd_write_q ? 2'd2 : 2'd3;

    // -------------------------------------------------------------------------
    // Access descriptor: what the current state/step puts on the bus
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        iss_wr   = 1'b0;
        iss_rd   = 1'b0;
        iss_adr  = 4'd0;
        iss_data = 32'd0;

        unique case (state_q)
            ST_INIT: begin
                iss_wr = 1'b1;
                unique case (step_q)
                    2'd0:    begin iss_adr = REG_SCL_LOW;  iss_data = SCL_LOW_CNT;  end
                    2'd1:    begin iss_adr = REG_SCL_HIGH; iss_data = SCL_HIGH_CNT; end
                    2'd2:    begin iss_adr = REG_SDA_HOLD; iss_data = SDA_HOLD_CNT; end
                    default: begin iss_adr = REG_CTRL;     iss_data = 32'h1;        end
                endcase
            end
            ST_PUSH: begin
                iss_wr  = 1'b1;
                iss_adr = REG_TFR_CMD;
                unique case (step_q)
                    2'd0:    iss_data = TFR_ADDR_WR;
                    2'd1:    iss_data = {24'd0, cmd_reg_q};
                    // Third word: STO + data for writes, repeated START + read
                    // address for reads.
                    2'd2:    iss_data = cmd_write_q ? {22'd0, 2'b01, cmd_wdata_q}
                                                    : TFR_ADDR_RD;
                    default: iss_data = TFR_RD_STOP;
                endcase
            end
            ST_POLL_STAT: begin iss_rd = 1'b1; iss_adr = REG_STATUS;  end
            ST_ISR_RD:    begin iss_rd = 1'b1; iss_adr = REG_ISR;     end
            ST_ISR_CLR:   begin iss_wr = 1'b1; iss_adr = REG_ISR; iss_data = ISR_NACK_CLR; end
            ST_POLL_RX:   begin iss_rd = 1'b1; iss_adr = REG_RX_LVL;  end
            ST_RX_RD:     begin iss_rd = 1'b1; iss_adr = REG_RX_DATA; end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        wr_rq_d     = wr_rq_q;
        rd_rq_d     = rd_rq_q;
        wr_adr_d    = wr_adr_q;
        rd_adr_d    = rd_adr_q;
        wr_data_d   = wr_data_q;
        poll_cnt_d  = poll_cnt_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cmd_write_d = cmd_write_q;
        cmd_reg_d   = cmd_reg_q;
        cmd_wdata_d = cmd_wdata_q;

        if (!access_busy) begin
            // A cycle with both requests low separates every pair of accesses:
            // the request that completed dropped last edge, the next rises now.
            if (iss_wr) begin
                wr_rq_d   = 1'b1;
                wr_adr_d  = iss_adr;
                wr_data_d = iss_data;
            end else if (iss_rd) begin
                rd_rq_d  = 1'b1;
                rd_adr_d = iss_adr;
            end
        end

        if (access_done) begin
            wr_rq_d = 1'b0;
            rd_rq_d = 1'b0;
        end

        unique case (state_q)
            ST_INIT: begin
                if (access_done) begin
                    if (step_q == 2'd3) begin
                        state_d = ST_IDLE;
                        step_d  = 2'd0;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end

            ST_IDLE: begin
                if (cmd_valid_i) begin
                    cmd_write_d = cmd_write_i;
                    cmd_reg_d   = cmd_reg_i;
                    cmd_wdata_d = cmd_wdata_i;
                    rsp_err_d   = 1'b0;
                    step_d      = 2'd0;
                    state_d     = ST_PUSH;
                end
            end

            ST_PUSH: begin
                if (access_done) begin
                    if (step_q == push_last) begin
                        step_d     = 2'd0;
                        poll_cnt_d = 16'd0;
                        state_d    = ST_POLL_STAT;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end

            ST_POLL_STAT: begin
                if (access_done) begin
                    poll_cnt_d = poll_cnt_inc;
                    if (!bus.rd_data[0]) begin
`ifdef I2C_EXP_NACK_CHECK_EN
                        state_d = ST_ISR_RD;
`else
                        poll_cnt_d = 16'd0;
                        state_d    = cmd_write_q ? ST_RESP : ST_POLL_RX;
`endif
                    end else if (poll_expired) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end

            ST_ISR_RD: begin
                if (access_done) begin
                    if (bus.rd_data[2]) begin
                        state_d = ST_ISR_CLR;
                    end else begin
                        poll_cnt_d = 16'd0;
                        state_d    = cmd_write_q ? ST_RESP : ST_POLL_RX;
                    end
                end
            end

            ST_ISR_CLR: begin
                if (access_done) begin
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end

            ST_POLL_RX: begin
                if (access_done) begin
                    poll_cnt_d = poll_cnt_inc;
                    // RX level is unsigned, so "at least one" is "non-zero"
                    if (bus.rd_data != 32'd0) begin
                        state_d = ST_RX_RD;
                    end else if (poll_expired) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end

            ST_RX_RD: begin
                if (access_done) begin
                    rsp_rdata_d = bus.rd_data[7:0];
                    state_d     = ST_RESP;
                end
            end

            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_INIT;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // The asynchronous reset drops both requests immediately and discards any
    // command in flight, so no partial response can follow a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            step_q      <= 2'd0;
            wr_rq_q     <= 1'b0;
            rd_rq_q     <= 1'b0;
            wr_adr_q    <= 4'd0;
            rd_adr_q    <= 4'd0;
            wr_data_q   <= 32'd0;
            poll_cnt_q  <= 16'd0;
            rsp_rdata_q <= 8'd0;
            rsp_err_q   <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_reg_q   <= 8'd0;
            cmd_wdata_q <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments here so every register updates
            // from the values of the previous cycle, independent of order.
            state_q     <= state_d;
            step_q      <= step_d;
            wr_rq_q     <= wr_rq_d;
            rd_rq_q     <= rd_rq_d;
            wr_adr_q    <= wr_adr_d;
            rd_adr_q    <= rd_adr_d;
            wr_data_q   <= wr_data_d;
            poll_cnt_q  <= poll_cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cmd_write_q <= cmd_write_d;
            cmd_reg_q   <= cmd_reg_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    assign bus.wr_rq   = wr_rq_q;
    assign bus.rd_rq   = rd_rq_q;
    assign bus.wr_adr  = wr_adr_q;
    assign bus.rd_adr  = rd_adr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: doc/i2c_expander_seq.md
Name: i2c_expander_seq

Overview:
- Command sequencer sitting directly upstream of the I2C expander MM bridge.
- Turns single-byte expander register read/write commands into ordered register accesses of the I2C master core (init, TFR_CMD pushes, status polling, RX fetch), using the bridge's wr_rq/rd_rq/action_done handshake.
- Returns read data and an error flag to the GPIO control logic above it.

Parameters:
- DEV_ADDR, 7'h20, 7-bit I2C address of the expander.
- SCL_LOW_CNT, 32'd250, value written to core reg 8 (SCL_LOW) at init.
- SCL_HIGH_CNT, 32'd250, value written to core reg 9 (SCL_HIGH) at init.
- SDA_HOLD_CNT, 32'd30, value written to core reg 10 (SDA_HOLD) at init.
- POLL_MAX, 16'd1000, maximum STATUS/RX-level polls before timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  sequencer idle and initialised; command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=register write, 0=register read
- cmd_reg  in  8  expander register index
- cmd_wdata  in  8  write byte
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read byte, valid with rsp_valid on reads
- rsp_err  out  1  error qualifier, valid with rsp_valid
- wr_rq  out  1  bridge write request (level)
- rd_rq  out  1  bridge read request (level)
- wr_adr  out  4  core register address for writes
- rd_adr  out  4  core register address for reads
- wr_data  out  32  core write data
- rd_data  in  32  core read data; sampled only in the action_done cycle of a read
- action_done  in  1  bridge access complete pulse

Behaviour:
- Reset values: all outputs 0 (cmd_ready=0, wr_rq=rd_rq=0, adr/data=0, rsp_*=0). State is INIT step 0. Poll counter is 0.
- Access handshake:
  - Exactly one of wr_rq/rd_rq is high at a time.
  - Address and data are stable while the request is high.
  - The request drops in the cycle after action_done is seen.
  - Both requests stay low for exactly one cycle before the next access.
  - A bridge write completes 1 cycle after the request rises; a read completes 2 cycles after.
  - For reads, rd_data[7:0] (or the full word for polling) is captured on the action_done cycle.
- Core register map:
  - 0 TFR_CMD: [9]=STA, [8]=STO, [7:0]=byte
  - 1 RX_DATA
  - 2 CTRL: [0]=EN
  - 4 ISR: [2]=NACK_DET, write-1-clear
  - 5 STATUS: [0]=busy
  - 7 RX_LVL
- States:
  - INIT: four writes in order: reg8=SCL_LOW_CNT, reg9=SCL_HIGH_CNT, reg10=SDA_HOLD_CNT, reg2=32'h1. Then go to IDLE. Runs once per reset.
  - IDLE: cmd_ready=1. On accept, latch cmd_write/cmd_reg/cmd_wdata (later cmd_* changes are ignored) and go to PUSH.
  - PUSH (write command), 3 words to reg0:
    - {STA, DEV_ADDR,0} = 0x200|DEV_ADDR<<1
    - {cmd_reg}
    - {STO, cmd_wdata}
  - PUSH (read command), 4 words to reg0:
    - 0x200|DEV_ADDR<<1
    - {cmd_reg}
    - 0x200|DEV_ADDR<<1|1
    - 0x100
  - POLL_STAT: read reg5 repeatedly until bit0=0, then go to RESP (write) or POLL_RX (read).
  - POLL_RX: read reg7 until the value is ≥1, then go to RX_RD.
  - RX_RD: read reg1 and latch [7:0] into rsp_rdata. Then go to RESP.
  - RESP: rsp_valid=1 for one cycle, then IDLE.
- Poll counter:
  - Cleared on entry to POLL_STAT and POLL_RX.
  - Increments per completed poll read.
  - Reaching POLL_MAX without success: rsp_err=1, skip remaining steps, go to RESP.
- rsp_rdata holds its last value until the next read completes. rsp_err is 0 on success.
- cmd_valid while not ready: ignored; the command is not queued.
- Reset mid-operation: returns to INIT immediately. Requests drop asynchronously. No partial response is emitted.

Optional Feature:
- Macro: I2C_EXP_NACK_CHECK_EN.
- Defined:
  - After POLL_STAT succeeds, read reg4 (ISR).
  - If bit2=1: write reg4=32'h4 to clear, set rsp_err=1, skip POLL_RX/RX_RD, go to RESP.
  - If bit2=0: continue as normal.
- Undefined: no ISR accesses. rsp_err is set only by timeout.

Test Plan:
- Reset release → exactly 4 writes: (8,250), (9,250), (10,30), (2,1). Then cmd_ready=1. No rd_rq during init.
- Write cmd_reg=0x06, cmd_wdata=0xF0, DEV_ADDR=0x20 → reg0 writes 0x240, 0x006, 0x1F0. Model returns STATUS busy ×3 then 0 → rsp_valid with rsp_err=0. Exactly one low cycle between every request.
- Read cmd_reg=0x00 → reg0 writes 0x240, 0x000, 0x241, 0x100. Then RX_LVL 0 then 1, RX_DATA=0x5A → rsp_rdata=0x5A, rsp_err=0.
- STATUS stuck at 1 with POLL_MAX=8 → exactly 8 reg5 reads, then rsp_valid with rsp_err=1, cmd_ready returns.
- Reset asserted during third TFR_CMD write → wr_rq=0 immediately, no rsp_valid. After release, full init sequence repeats.
- With I2C_EXP_NACK_CHECK_EN, ISR=0x4 after write → reg4 read, then reg4 write 0x4, rsp_err=1. Without the macro, no reg4 access and rsp_err=0.
